// File: rtl/tff_pkg.sv
// ============================================================================
// Module   : tff_pkg
// Brief    : Shared state encoding and default sizes for the toggle-stage
//            pulse counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_def_width       = 8;
  localparam int c_def_sync_stages = 2;
  localparam int c_def_timeout     = 1023;
  localparam int c_timer_w         = 10;

endpackage

`default_nettype wire

// File: rtl/tff_sync_edge.sv
// ============================================================================
// Module   : tff_sync_edge
// Brief    : Multi-flop synchroniser plus registered rising-edge detector for
//            the asynchronous toggle-stage output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic rise_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d1;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Registering the detector gives a rise-to-edge latency of SYNC_STAGES+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_s_d1    <= 1'b0;
      rise_edge <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], pulse_in};
      r_s_d1    <= w_s;
      rise_edge <= w_s & ~r_s_d1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tff_pulse_counter.sv
// ============================================================================
// Module   : tff_pulse_counter
// Brief    : Counts synchronised rising edges of the toggle stage against a
//            programmed target with a done/ack handshake.
//            Optional idle timeout: define PULSE_CNT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_pulse_counter
  import tff_pkg::*;
#(
  parameter int WIDTH       = c_def_width,
  parameter int SYNC_STAGES = c_def_sync_stages
`ifdef PULSE_CNT_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = c_def_timeout
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             overflow
`ifdef PULSE_CNT_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_target_q;
  logic             w_edge;
  logic [WIDTH-1:0] w_count_inc;

  assign w_count_inc = count + WIDTH'(1);

  tff_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .rise_edge (w_edge)
  );

`ifdef PULSE_CNT_TIMEOUT_EN
  logic [c_timer_w-1:0] r_timer;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_target_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
`ifdef PULSE_CNT_TIMEOUT_EN
      r_timer    <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_target_q <= target;
            count      <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            r_state    <= ARM;
`ifdef PULSE_CNT_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
          end
        end
        // Any edge in flight here belongs to a pulse that began before the run.
        ARM: begin
`ifdef PULSE_CNT_TIMEOUT_EN
          r_timer <= '0;
`endif
          if (r_target_q == '0) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (w_edge) begin
            count <= w_count_inc;
            if (count == '1) begin
              overflow <= 1'b1;
            end
`ifdef PULSE_CNT_TIMEOUT_EN
            r_timer <= '0;
`endif
            if (w_count_inc == r_target_q) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= DONE;
            end
          end
`ifdef PULSE_CNT_TIMEOUT_EN
          else if (r_timer == c_timer_w'(TIMEOUT - 1)) begin
            r_timer <= c_timer_w'(TIMEOUT);
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + c_timer_w'(1);
          end
`endif
        end
        DONE: begin
          if (ack) begin
            done    <= 1'b0;
            r_state <= IDLE;
`ifdef PULSE_CNT_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tff_pulse_counter.sv
// ============================================================================
// Module   : tb_tff_pulse_counter
// Brief    : Directed vector table plus hand-written corner sequences for
//            tff_pulse_counter. Timeout checks need PULSE_CNT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tff_pulse_counter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             pulse_in;
  logic             start;
  logic [WIDTH-1:0] target;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic             overflow;
`ifdef PULSE_CNT_TIMEOUT_EN
  logic             timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tff_pulse_counter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
`ifdef PULSE_CNT_TIMEOUT_EN
    ,
    .TIMEOUT     (20)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .start    (start),
    .target   (target),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
`ifdef PULSE_CNT_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] tgt;
    int               pulses;
    int               half;
    logic [WIDTH-1:0] exp_count;
    logic             exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Leaves the DUT in COUNT (or DONE for target 0) one cycle after ARM.
  task automatic do_start(input logic [WIDTH-1:0] t);
    target = t;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
  endtask

  task automatic pulse(input int half);
    pulse_in = 1'b1;
    repeat (half) tick();
    pulse_in = 1'b0;
    repeat (half) tick();
  endtask

  initial begin
    int c0;
    reset    = 1'b0;
    pulse_in = 1'b0;
    start    = 1'b0;
    target   = '0;
    ack      = 1'b0;

    vecs[0] = '{tgt: 8'd4,   pulses: 4, half: 6, exp_count: 8'd4, exp_done: 1'b1};
    vecs[1] = '{tgt: 8'd1,   pulses: 1, half: 3, exp_count: 8'd1, exp_done: 1'b1};
    vecs[2] = '{tgt: 8'd0,   pulses: 0, half: 3, exp_count: 8'd0, exp_done: 1'b1};
    vecs[3] = '{tgt: 8'd3,   pulses: 2, half: 4, exp_count: 8'd2, exp_done: 1'b0};
    vecs[4] = '{tgt: 8'd255, pulses: 5, half: 3, exp_count: 8'd5, exp_done: 1'b0};
    vecs[5] = '{tgt: 8'd2,   pulses: 5, half: 3, exp_count: 8'd2, exp_done: 1'b1};

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);

    // Table-driven runs
    foreach (vecs[i]) begin
      do_reset();
      do_start(vecs[i].tgt);
      for (int p = 0; p < vecs[i].pulses; p++) pulse(vecs[i].half);
      repeat (8) tick();
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      chk($sformatf("v%0d_busy", i), busy, !vecs[i].exp_done);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
      if (vecs[i].exp_done) begin
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk($sformatf("v%0d_ack_done", i), done, 0);
        chk($sformatf("v%0d_ack_count", i), count, vecs[i].exp_count);
        chk($sformatf("v%0d_ack_busy", i), busy, 0);
      end
    end

    // Exact latency: 4th edge completes one cycle after it reaches the FSM
    do_reset();
    do_start(8'd4);
    for (int p = 0; p < 3; p++) pulse(6);
    pulse_in = 1'b1;
    repeat (3) tick();
    chk("lat_done_early", done, 0);
    chk("lat_count_early", count, 3);
    tick();
    chk("lat_done", done, 1);
    chk("lat_count", count, 4);
    chk("lat_busy", busy, 0);
    repeat (5) tick();
    pulse_in = 1'b0;
    repeat (6) tick();

    // target=0: ARM on first cycle after start, DONE on the second
    do_reset();
    target = 8'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("t0_arm_busy", busy, 1);
    chk("t0_arm_done", done, 0);
    tick();
    chk("t0_done", done, 1);
    chk("t0_busy", busy, 0);
    chk("t0_count", count, 0);

    // ack and start together in DONE: ack wins, start dropped
    ack    = 1'b1;
    start  = 1'b1;
    target = 8'd3;
    tick();
    ack    = 1'b0;
    start  = 1'b0;
    chk("ackstart_done", done, 0);
    chk("ackstart_busy", busy, 0);
    repeat (2) tick();
    chk("ackstart_busy_later", busy, 0);

    // Reset mid-COUNT after 3 edges
    do_reset();
    do_start(8'd5);
    for (int p = 0; p < 3; p++) pulse(4);
    repeat (4) tick();
    chk("midrst_pre_count", count, 3);
    chk("midrst_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", count, 0);
    for (int p = 0; p < 3; p++) pulse(4);
    repeat (4) tick();
    chk("midrst_idle_count", count, 0);
    chk("midrst_idle_busy", busy, 0);

    // ack and start outside their states are ignored
    do_reset();
    do_start(8'd5);
    pulse(4);
    repeat (4) tick();
    ack    = 1'b1;
    start  = 1'b1;
    target = 8'd1;
    tick();
    ack    = 1'b0;
    start  = 1'b0;
    repeat (2) tick();
    chk("ign_busy", busy, 1);
    chk("ign_count", count, 1);
    pulse(4);
    repeat (4) tick();
    chk("ign_count2", count, 2);
    chk("ign_done", done, 0);

    // 1-clk pulse may be missed, never double counted
    c0 = int'(count);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (!(int'(count) == c0 || int'(count) == c0 + 1)) begin
      n_errors++;
      $display("FAIL short_pulse: got %0d expected %0d or %0d", count, c0, c0 + 1);
    end
    c0 = int'(count);
    pulse(4);
    repeat (4) tick();
    chk("short_then_full", count, c0 + 1);

`ifdef PULSE_CNT_TIMEOUT_EN
    // Timeout 20 cycles after the last counted edge
    do_reset();
    do_start(8'd10);
    for (int p = 0; p < 2; p++) pulse(6);
    pulse_in = 1'b1;
    repeat (6) tick();
    pulse_in = 1'b0;
    repeat (17) tick();
    chk("to_done_early", done, 0);
    chk("to_flag_early", timeout, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_count", count, 3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("to_ack_done", done, 0);
    chk("to_ack_flag", timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
